// File: rtl/lsu_mem_stage_if.sv
// lsu_mem_stage_if: request/acknowledge data-memory bus between the LSU and memory.
interface lsu_mem_stage_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    modport master(output bus_req, bus_we, bus_addr, bus_wdata, bus_be, input bus_ack, bus_rdata);
    modport slave(input bus_req, bus_we, bus_addr, bus_wdata, bus_be, output bus_ack, bus_rdata);
endinterface

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: RV32I load/store stage; one bus transaction per access, stalls the core until done.
// Define MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of ignoring the low address bits.
module lsu_mem_stage #(
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_re,
    input  logic             mem_we,
    input  logic [2:0]       funct3,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    output logic             stall,
    output logic [31:0]      rdata,
    output logic             bus_err,
    output logic             misalign,
    lsu_mem_stage_if.master  bus
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    state_t      state;
    logic [7:0]  cnt;
    logic [2:0]  f3;
    logic [1:0]  a_lo;
    logic        st;
    logic        legal, mis;
    logic [3:0]  be_n;
    logic [31:0] wd_n, sh, ext;
    logic [15:0] hw;
    always_comb begin
        legal = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
`ifdef MISALIGN_TRAP_EN
        mis = (funct3[1:0] == 2'b01 && addr[0]) || (funct3 == 3'b010 && addr[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        be_n = !mem_we ? 4'b1111 :
               funct3[1:0] == 2'b00 ? 4'b0001 << addr[1:0] :
               funct3[1:0] == 2'b01 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wd_n = funct3[1:0] == 2'b00 ? {4{wdata[7:0]}} :
               funct3[1:0] == 2'b01 ? {2{wdata[15:0]}} : wdata;
        sh   = bus.bus_rdata >> {a_lo, 3'b000};
        hw   = a_lo[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
        ext  = f3 == 3'b000 ? {{24{sh[7]}}, sh[7:0]} :
               f3 == 3'b001 ? {{16{hw[15]}}, hw} :
               f3 == 3'b100 ? {24'd0, sh[7:0]} :
               f3 == 3'b101 ? {16'd0, hw} : bus.bus_rdata;
    end
    assign stall = !rst && (state == REQ || (state == IDLE && (mem_re || mem_we)));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            f3            <= '0;
            a_lo          <= '0;
            st            <= 1'b0;
            rdata         <= '0;
            bus_err       <= 1'b0;
            misalign      <= 1'b0;
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= '0;
            bus.bus_wdata <= '0;
            bus.bus_be    <= '0;
        end else begin
            bus_err  <= 1'b0;
            misalign <= 1'b0;
            case (state)
                IDLE: if (mem_re || mem_we) begin
                    f3   <= funct3;
                    a_lo <= addr[1:0];
                    st   <= mem_we;
                    cnt  <= '0;
                    // Illegal or trapped accesses skip the bus and complete immediately
                    if (!legal || mis) begin
                        state    <= DONE;
                        misalign <= mis;
                        if (!mem_we) rdata <= '0;
                    end else begin
                        state         <= REQ;
                        bus.bus_req   <= 1'b1;
                        bus.bus_we    <= mem_we;
                        bus.bus_addr  <= {addr[31:2], 2'b00};
                        bus.bus_wdata <= wd_n;
                        bus.bus_be    <= be_n;
                    end
                end
                REQ: if (bus.bus_ack) begin
                    state       <= DONE;
                    bus.bus_req <= 1'b0;
                    bus.bus_we  <= 1'b0;
                    if (!st) rdata <= ext;
                end else if (cnt == 8'(TIMEOUT - 1)) begin
                    state       <= DONE;
                    bus.bus_req <= 1'b0;
                    bus.bus_we  <= 1'b0;
                    bus_err     <= 1'b1;
                    if (!st) rdata <= '0;
                end else begin
                    cnt <= cnt + 8'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb_lsu_mem_stage: vector table, hand-written corner sequences and randomized ops against a reference model.
module tb_lsu_mem_stage;
    localparam int TO = 64;
`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    typedef struct {
        int          stall_cyc;
        logic        req, we, err, mis, stable, tail;
        logic [31:0] addr, wd, rd;
        logic [3:0]  be;
    } obs_t;
    typedef struct {
        logic        re, we;
        logic [2:0]  f3;
        logic [31:0] a, wd, rw;
        int          dly;
        obs_t        e;
    } vec_t;

    logic        clk = 1'b0, rst = 1'b1;
    logic        mem_re = 1'b0, mem_we = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] addr = '0, wdata = '0;
    logic        stall, bus_err, misalign;
    logic [31:0] rdata;
    int          errs = 0, checks = 0;
    vec_t        tbl[$];
    logic [31:0] model_rd;

    lsu_mem_stage_if bus_i();
    lsu_mem_stage #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .mem_re(mem_re), .mem_we(mem_we), .funct3(funct3),
        .addr(addr), .wdata(wdata), .stall(stall), .rdata(rdata),
        .bus_err(bus_err), .misalign(misalign), .bus(bus_i.master)
    );
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_op(input logic re, we, input logic [2:0] f3, input logic [31:0] a, wd, rw,
                          input int dly, output obs_t o);
        int n, rq;
        o = '{default: 0};
        o.stable = 1'b1;
        n = 0;
        rq = 0;
        @(negedge clk);
        mem_re = re; mem_we = we; funct3 = f3; addr = a; wdata = wd;
        #1;
        while (stall && n < 400) begin
            o.stall_cyc++;
            if (bus_i.bus_req) begin
                if (!o.req) begin
                    o.req = 1'b1; o.we = bus_i.bus_we; o.addr = bus_i.bus_addr;
                    o.be = bus_i.bus_be; o.wd = bus_i.bus_wdata;
                end else if ({bus_i.bus_we, bus_i.bus_addr, bus_i.bus_be, bus_i.bus_wdata} !== {o.we, o.addr, o.be, o.wd})
                    o.stable = 1'b0;
                bus_i.bus_ack = (rq == dly);
                bus_i.bus_rdata = rw;
                rq++;
            end
            @(negedge clk);
            bus_i.bus_ack = 1'b0;
            #1;
            n++;
        end
        o.rd = rdata; o.err = bus_err; o.mis = misalign;
        mem_re = 1'b0; mem_we = 1'b0;
        @(negedge clk);
        #1;
        o.tail = !bus_err && !misalign && !bus_i.bus_req && !stall;
    endtask

    task automatic cmp(input string t, input obs_t o, input obs_t e);
        chk({t, ".stall_cycles"}, o.stall_cyc, e.stall_cyc);
        chk({t, ".bus_req"}, o.req, e.req);
        chk({t, ".rdata"}, o.rd, e.rd);
        chk({t, ".bus_err"}, o.err, e.err);
        chk({t, ".misalign"}, o.mis, e.mis);
        chk({t, ".pulse_end"}, o.tail, 1'b1);
        if (e.req) begin
            chk({t, ".bus_addr"}, o.addr, e.addr);
            chk({t, ".bus_be"}, o.be, e.be);
            chk({t, ".bus_we"}, o.we, e.we);
            chk({t, ".bus_stable"}, o.stable, 1'b1);
            if (e.we) chk({t, ".bus_wdata"}, o.wd, e.wd);
        end
    endtask

    function automatic obs_t model(input logic re, we, input logic [2:0] f3, input logic [31:0] a, wd, rw,
                                   input int dly, input logic [31:0] prev);
        obs_t e;
        int lane;
        logic [31:0] b, h, ld;
        bit legal, trap, tmo;
        e = '{default: 0};
        e.stable = 1'b1; e.tail = 1'b1;
        lane = int'(a % 4);
        legal = (f3 != 3 && f3 < 6);
        trap = TRAP && ((f3 % 4 == 1 && a % 2 == 1) || (f3 == 2 && lane != 0));
        e.rd = prev;
        if (!legal || trap) begin
            e.stall_cyc = 1; e.mis = trap;
            if (!we) e.rd = 0;
            return e;
        end
        tmo = dly >= TO;
        e.req = 1'b1; e.we = we; e.addr = a - 32'(lane); e.err = tmo;
        e.stall_cyc = tmo ? TO + 1 : dly + 2;
        e.be = !we ? 4'hF : f3 % 4 == 0 ? 4'(1 << lane) : f3 % 4 == 1 ? (lane >= 2 ? 4'hC : 4'h3) : 4'hF;
        e.wd = f3 % 4 == 0 ? wd[7:0] * 32'h01010101 : f3 % 4 == 1 ? wd[15:0] * 32'h00010001 : wd;
        b = (rw >> (8 * lane)) & 32'hFF;
        h = (rw >> (lane >= 2 ? 16 : 0)) & 32'hFFFF;
        ld = f3 == 0 ? (b >= 128 ? b | 32'hFFFFFF00 : b) :
             f3 == 1 ? (h >= 32768 ? h | 32'hFFFF0000 : h) :
             f3 == 4 ? b : f3 == 5 ? h : rw;
        if (!we) e.rd = tmo ? 32'd0 : ld;
        return e;
    endfunction

    task automatic add(input logic re, we, input logic [2:0] f3, input logic [31:0] a, wd, rw, input int dly,
                       input int sc, input logic rq, ewe, input logic [31:0] ea, input logic [3:0] ebe,
                       input logic [31:0] ewd, erd, input logic eerr, emis);
        vec_t v;
        v.re = re; v.we = we; v.f3 = f3; v.a = a; v.wd = wd; v.rw = rw; v.dly = dly;
        v.e = '{default: 0};
        v.e.stall_cyc = sc; v.e.req = rq; v.e.we = ewe; v.e.addr = ea; v.e.be = ebe;
        v.e.wd = ewd; v.e.rd = erd; v.e.err = eerr; v.e.mis = emis; v.e.stable = 1'b1; v.e.tail = 1'b1;
        tbl.push_back(v);
    endtask

    initial begin
        obs_t o, e;
        logic re, we;
        logic [2:0] f3;
        logic [31:0] a, wd, rw;
        int dly;
        logic [2:0] ld_f3[8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        logic [2:0] st_f3[5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6};
        add(1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0, 2, 1, 0, 32'h100, 4'hF, 0, 32'hDEADBEEF, 0, 0);
        add(1, 0, 3'b000, 32'h203, 0, 32'h80112233, 0, 2, 1, 0, 32'h200, 4'hF, 0, 32'hFFFFFF80, 0, 0);
        add(1, 0, 3'b100, 32'h203, 0, 32'h80112233, 0, 2, 1, 0, 32'h200, 4'hF, 0, 32'h00000080, 0, 0);
        add(0, 1, 3'b001, 32'h42, 32'h0000ABCD, 0, 0, 2, 1, 1, 32'h40, 4'hC, 32'hABCDABCD, 32'h80, 0, 0);
        add(0, 1, 3'b000, 32'h05, 32'h12345678, 0, 3, 5, 1, 1, 32'h4, 4'h2, 32'h78787878, 32'h80, 0, 0);
        add(1, 0, 3'b001, 32'h06, 0, 32'h80017FFF, 1, 3, 1, 0, 32'h4, 4'hF, 0, 32'hFFFF8001, 0, 0);
        add(1, 0, 3'b101, 32'h06, 0, 32'h80017FFF, 2, 4, 1, 0, 32'h4, 4'hF, 0, 32'h00008001, 0, 0);
        add(1, 0, 3'b011, 32'h10, 0, 32'h5A5A5A5A, 0, 1, 0, 0, 0, 0, 0, 32'h0, 0, 0);
        add(0, 1, 3'b010, 32'h20, 32'hCAFEF00D, 0, 0, 2, 1, 1, 32'h20, 4'hF, 32'hCAFEF00D, 32'h0, 0, 0);
`ifdef MISALIGN_TRAP_EN
        add(1, 0, 3'b010, 32'h101, 0, 32'h11223344, 0, 1, 0, 0, 0, 0, 0, 32'h0, 0, 1);
        add(1, 0, 3'b001, 32'h103, 0, 32'hF00F0000, 0, 1, 0, 0, 0, 0, 0, 32'h0, 0, 1);
        add(1, 1, 3'b000, 32'h03, 32'hAB, 0, 0, 2, 1, 1, 32'h0, 4'h8, 32'hABABABAB, 32'h0, 0, 0);
`else
        add(1, 0, 3'b010, 32'h101, 0, 32'h11223344, 0, 2, 1, 0, 32'h100, 4'hF, 0, 32'h11223344, 0, 0);
        add(1, 0, 3'b001, 32'h103, 0, 32'hF00F0000, 0, 2, 1, 0, 32'h100, 4'hF, 0, 32'hFFFFF00F, 0, 0);
        add(1, 1, 3'b000, 32'h03, 32'hAB, 0, 0, 2, 1, 1, 32'h0, 4'h8, 32'hABABABAB, 32'hFFFFF00F, 0, 0);
`endif
        add(1, 0, 3'b010, 32'h300, 0, 32'h12345678, 200, TO + 1, 1, 0, 32'h300, 4'hF, 0, 32'h0, 1, 0);
        add(0, 1, 3'b111, 32'h44, 32'h1, 0, 0, 1, 0, 0, 0, 0, 0, 32'h0, 0, 0);

        bus_i.bus_ack = 1'b0;
        bus_i.bus_rdata = '0;
        #3;
        chk("reset.stall", stall, 0);
        chk("reset.rdata", rdata, 0);
        chk("reset.bus_req", bus_i.bus_req, 0);
        chk("reset.bus_addr", bus_i.bus_addr, 0);
        chk("reset.bus_be", bus_i.bus_be, 0);
        chk("reset.bus_err", bus_err, 0);
        chk("reset.misalign", misalign, 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            run_op(tbl[i].re, tbl[i].we, tbl[i].f3, tbl[i].a, tbl[i].wd, tbl[i].rw, tbl[i].dly, o);
            cmp($sformatf("vec%0d", i), o, tbl[i].e);
        end

        // Reset in the middle of a request abandons it immediately
        @(negedge clk);
        mem_re = 1'b1; funct3 = 3'b010; addr = 32'h400;
        @(negedge clk);
        #1;
        chk("rst_mid.req_before", bus_i.bus_req, 1);
        rst = 1'b1;
        #1;
        chk("rst_mid.bus_req", bus_i.bus_req, 0);
        chk("rst_mid.stall", stall, 0);
        @(negedge clk);
        rst = 1'b0; mem_re = 1'b0;
        model_rd = 32'h0;
        run_op(0, 1, 3'b010, 32'h48, 32'h0BADF00D, 0, 1, o);
        e = model(0, 1, 3'b010, 32'h48, 32'h0BADF00D, 0, 1, model_rd);
        cmp("rst_mid.store", o, e);
        model_rd = e.rd;

        // A stray ack outside a request must not disturb rdata
        run_op(1, 0, 3'b010, 32'h50, 0, 32'h13579BDF, 0, o);
        e = model(1, 0, 3'b010, 32'h50, 0, 32'h13579BDF, 0, model_rd);
        cmp("pre_stray", o, e);
        model_rd = e.rd;
        @(negedge clk);
        bus_i.bus_ack = 1'b1; bus_i.bus_rdata = 32'h55555555;
        @(negedge clk);
        bus_i.bus_ack = 1'b0;
        #1;
        chk("stray_ack.rdata", rdata, model_rd);
        chk("stray_ack.bus_req", bus_i.bus_req, 0);
        chk("stray_ack.stall", stall, 0);

        for (int k = 0; k < 60; k++) begin
            we = 1'($urandom_range(0, 1));
            re = we ? 1'($urandom_range(0, 1)) : 1'b1;
            f3 = we ? st_f3[$urandom_range(0, 4)] : ld_f3[$urandom_range(0, 7)];
            a = $urandom; wd = $urandom; rw = $urandom;
            dly = ($urandom_range(0, 9) == 0) ? 200 : int'($urandom_range(0, 4));
            run_op(re, we, f3, a, wd, rw, dly, o);
            e = model(re, we, f3, a, wd, rw, dly, model_rd);
            cmp($sformatf("rnd%0d", k), o, e);
            model_rd = e.rd;
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
